// File: rtl/ps2_rx_pkg.sv
// Shared types and frame constants for the PS/2 receive path.
package ps2_rx_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  // Receiver state
  //   state     | meaning
  //   ST_IDLE   | waiting for a start bit (fall with data=0 and RX_En_Sig=1)
  //   ST_DATA   | shifting in the 8 data bits, LSB first
  //   ST_PARITY | sampling the parity bit, latching the odd-parity verdict
  //   ST_STOP   | sampling the stop bit, then reporting Done or Err
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  // Odd parity holds when the data XOR and the parity bit together are 1.
  function automatic logic odd_parity_ok(input logic data_xor, input logic parity_bit);
    return data_xor ^ parity_bit;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the raw PS/2 pins into the CLK domain and flags PS/2 clock falls.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_pin,
  input  logic ps2_data_pin,
  output logic fall,
  output logic data
);

  logic [2:0] clk_sync;
  logic [1:0] data_sync;

  // Synchronisers reset to 1 so a bus at rest never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk_pin};
      data_sync <= {data_sync[0], ps2_data_pin};
    end
  end

  // The third clock stage lets the fall be seen in the same cycle as the
  // second data stage, so both paths have equal delay.
  assign fall = clk_sync[2] & ~clk_sync[1];
  assign data = data_sync[1];

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd
// parity, stop. Reports a good byte with a Done pulse, anything else with Err.
module ps2_rx_frame
  import ps2_rx_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK_Pin,
  input  logic       PS2_Data_Pin,
  input  logic       RX_En_Sig,
  output logic [7:0] RX_Data,
  output logic       RX_Done_Sig,
  output logic       RX_Err_Sig
);

  localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BCNT_W = $clog2(PS2_DATA_BITS);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(PS2_DATA_BITS - 1);

  logic                     fall;
  logic                     data;
  rx_state_e                state;
  logic [BCNT_W-1:0]        bit_cnt;
  logic [PS2_DATA_BITS-1:0] shift_reg;
  logic                     par_acc;
  logic                     parity_ok;
  logic [TO_W-1:0]          to_cnt;

  ps2_sync_edge u_sync (
    .clk          (CLK),
    .rst          (RST),
    .ps2_clk_pin  (PS2_CLK_Pin),
    .ps2_data_pin (PS2_Data_Pin),
    .fall         (fall),
    .data         (data)
  );

  // Frame FSM with shift register, parity accumulator, timeout and pulse outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      par_acc     <= 1'b0;
      parity_ok   <= 1'b0;
      to_cnt      <= '0;
      RX_Data     <= 8'h00;
      RX_Done_Sig <= 1'b0;
      RX_Err_Sig  <= 1'b0;
    end else begin
      RX_Done_Sig <= 1'b0;
      RX_Err_Sig  <= 1'b0;

      // Saturating so a stalled frame can never wrap back under the limit.
      if (state == ST_IDLE || fall) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (state != ST_IDLE && !fall && to_cnt == TO_MAX) begin
        state      <= ST_IDLE;
        RX_Err_Sig <= 1'b1;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!data && RX_En_Sig) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
              par_acc <= 1'b0;
            end
          end
          ST_DATA: begin
            shift_reg <= {data, shift_reg[PS2_DATA_BITS-1:1]};
            par_acc   <= par_acc ^ data;
            if (bit_cnt == BIT_LAST) begin
              state <= ST_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            parity_ok <= odd_parity_ok(par_acc, data);
            state     <= ST_STOP;
          end
          ST_STOP: begin
            if (data && parity_ok) begin
              RX_Data     <= shift_reg;
              RX_Done_Sig <= 1'b1;
            end else begin
              RX_Err_Sig <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_rx_frame.md
PS2_RX_FRAME -- requirements
Module: ps2_rx_frame

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 50000, meaning CLK cycles without a PS/2 falling edge before an in-progress frame is aborted (1 ms at 50 MHz).
REQ-002 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have port PS2_CLK_Pin  input  1  raw asynchronous PS/2 clock from the keyboard.
REQ-005 SHALL have port PS2_Data_Pin  input  1  raw asynchronous PS/2 data from the keyboard.
REQ-006 SHALL have port RX_En_Sig  input  1  downstream ready: reception is allowed to start only while high.
REQ-007 SHALL have port RX_Data  output  8  last correctly received byte.
REQ-008 SHALL have port RX_Done_Sig  output  1  one-cycle pulse; RX_Data is valid in the same cycle.
REQ-009 SHALL have port RX_Err_Sig  output  1  one-cycle pulse on a framing, parity or timeout error.

Function
REQ-010 SHALL pass both pins through 2-FF synchronisers, plus a third FF on the clock path; fall = third FF high AND second FF low; a pin edge yields fall 2 cycles later.
REQ-011 SHALL sample the synchronised data bit only in cycles where fall is high.
REQ-012 SHALL implement states IDLE, DATA, PARITY, STOP and report via registered outputs.
REQ-013 IDLE: on fall with data=0 and RX_En_Sig=1 -> DATA, with bit count 0 and parity accumulator cleared.
REQ-014 IDLE: fall with data=1, or with RX_En_Sig=0, SHALL be ignored; state stays IDLE.
REQ-015 DATA: each fall shifts the bit in LSB-first and XORs it into the accumulator; after the 8th bit -> PARITY.
REQ-016 PARITY: on fall, record parity_ok = (XOR of 8 data bits XOR parity bit) == 1 (odd parity) -> STOP.
REQ-017 STOP: on fall with data=1 and parity_ok -> RX_Data loads the shift register, RX_Done_Sig pulses in the next cycle, -> IDLE.
REQ-018 STOP: on fall with data=0 or parity not ok -> RX_Err_Sig pulses in the next cycle; RX_Data is unchanged; -> IDLE.
REQ-019 A timeout counter SHALL clear on every fall and whenever in IDLE, and increment otherwise.
REQ-020 When the timeout counter reaches TIMEOUT_CYC-1 outside IDLE -> IDLE with one RX_Err_Sig pulse; no partial data is output.
REQ-021 RX_En_Sig SHALL be sampled only at the start bit; deasserting it mid-frame does not abort the frame.
REQ-022 RX_Done_Sig and RX_Err_Sig SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per frame.
REQ-023 RX_Data SHALL hold its value between Done pulses.
REQ-024 Latency: the stop-bit falling pin edge -> RX_Done_Sig high exactly 3 CLK cycles later.
REQ-025 The timeout counter width SHALL be $clog2(TIMEOUT_CYC) and SHALL saturate, never wrap.

Reset
REQ-026 RST high SHALL, at the next CLK edge, force state IDLE, counters 0, shift register 0, RX_Data 8'h00, RX_Done_Sig 0, RX_Err_Sig 0 and all synchroniser FFs 1 (bus idle).
REQ-027 RST asserted mid-frame SHALL discard the partial frame with no Done or Err pulse.
REQ-028 The first frame after RST release SHALL be received normally if its start edge follows the release by at least 3 cycles.

Structure
REQ-029 Package ps2_rx_pkg SHALL hold the state enum and the constants PS2_DATA_BITS=8 and PS2_FRAME_BITS=11.
REQ-030 A sub-module ps2_sync_edge SHALL contain the synchronisers and the fall detector; the FSM, shift register and timeout counter stay in ps2_rx_frame.

Verification
REQ-031 Frame 0x1C (parity 0, stop 1) with RX_En_Sig=1 -> RX_Data=8'h1C, one Done pulse 3 cycles after the stop edge, no Err.
REQ-032 Frame 0xF0 (parity 1) followed by frame 0x1C -> two Done pulses, with RX_Data 8'hF0 then 8'h1C.
REQ-033 Frame 0x1C with parity 1 -> one Err pulse, no Done, RX_Data keeps its previous value.
REQ-034 Frame aborted after 5 data bits, idle for TIMEOUT_CYC cycles -> one Err pulse and return to IDLE; the next frame 0x29 (parity 0) -> Done, RX_Data=8'h29.
REQ-035 Frame 0x1C with RX_En_Sig=0 at the start bit -> no Done and no Err; RX_En_Sig dropped after the start bit -> frame still completes with Done.
REQ-036 RST pulsed after 4 data bits -> outputs return to reset values, no pulses; the next full frame 0x1C is received correctly.
